sys_ctrl_rx_decoder: RTL and testbench
======================================

Name: sys_ctrl_rx_decoder

Overview:
- Parametrised second-generation UART-RX command decoder for the system controller.
- Parses framed command bytes from the UART receiver into register-file write/read strobes and ALU enable/function strobes.
- Adds three things the first generation lacks: registered outputs, address range checking with frame-error reporting, and an optional inter-byte timeout.
- Sits between UART_RX (after data sync) and RegFile/ALU/clock-gate in the CLK reference domain.

Parameters:
- DATA_W, 8, width of received byte and of register write data.
- ADDR_W, 4, register-file address width; address bytes with nonzero bits above ADDR_W are illegal.
- OPA_ADDR, 0, register-file address receiving ALU operand A.
- OPB_ADDR, 1, register-file address receiving ALU operand B.
- TIMEOUT_CYC, 1024, idle cycles allowed between bytes of one frame (timeout feature only); minimum 2.

Ports:
- CLK  in  1  reference clock.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_W  received byte.
- RX_D_VLD  in  1  single-cycle valid for RX_P_DATA.
- WR_EN  out  1  register-file write strobe.
- RD_EN  out  1  register-file read strobe.
- ADDR  out  ADDR_W  register-file address.
- WR_DATA  out  DATA_W  register-file write data.
- ALU_EN  out  1  ALU execute strobe.
- ALU_FUN  out  4  ALU function code.
- ALU_CLK_EN  out  1  ALU clock-gate enable.
- BUSY  out  1  high whenever a frame is in progress (state != IDLE).
- FRAME_ERR  out  1  one-cycle pulse on illegal opcode, illegal address or timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, operand/address/function holding registers 0. Reset mid-frame discards the frame; no strobe issued.
- All outputs are registered. Strobes appear exactly 1 cycle after the CLK edge that accepts the completing byte. Strobes last 1 cycle; otherwise ADDR/WR_DATA/ALU_FUN return to 0.
- A byte is accepted only on a cycle with RX_D_VLD=1. Back-to-back valid bytes every cycle are supported with no loss.
- Opcodes, accepted in IDLE:
  - 0xAA write -> WR_ADDR.
  - 0xBB read -> RD_ADDR.
  - 0xCC ALU with operands -> OPA.
  - 0xDD ALU without operands -> FUN.
  - Any other byte: stay IDLE, pulse FRAME_ERR.
- WR_ADDR:
  - Legal byte is latched into the address register -> WR_DATA.
  - Illegal byte (bits [DATA_W-1:ADDR_W] nonzero) -> IDLE + FRAME_ERR.
- WR_DATA: byte -> WR_EN=1, ADDR=latched address, WR_DATA=byte; -> IDLE.
- RD_ADDR:
  - Legal byte -> RD_EN=1, ADDR=byte[ADDR_W-1:0]; -> IDLE.
  - Illegal byte -> IDLE + FRAME_ERR.
- OPA: byte -> WR_EN=1, ADDR=OPA_ADDR, WR_DATA=byte; -> OPB.
- OPB: byte -> WR_EN=1, ADDR=OPB_ADDR, WR_DATA=byte; -> FUN.
- FUN: byte -> ALU_EN=1, ALU_FUN=byte[3:0] (upper bits ignored); -> IDLE.
- ALU_CLK_EN: 1 while state is OPA, OPB or FUN and during the ALU_EN cycle; 0 otherwise.
- BUSY: registered, high from the cycle after opcode acceptance until the cycle the completing strobe is issued (inclusive of the strobe cycle: BUSY falls together with the strobe's following edge).
- No command queueing. A new opcode is accepted the cycle after the completing byte.

Optional Feature:
- Macro: SYS_CTRL_RX_TIMEOUT_EN.
- Defined:
  - Counter clears on every accepted byte and in IDLE; it increments each non-IDLE cycle without RX_D_VLD.
  - When it reaches TIMEOUT_CYC-1: -> IDLE, FRAME_ERR pulse, no strobes.
  - RX_D_VLD in the expiry cycle wins: the byte is processed and there is no timeout.
- Not defined: no counter; a non-IDLE state waits indefinitely.

Decomposition:
- Package sys_ctrl_pkg holds:
  - opcode constants CMD_RF_WR=0xAA, CMD_RF_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - state enum typedef (IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN);
  - ALU function width constant 4.
- One sub-module: sys_ctrl_timeout_cnt, a parametrised inter-byte counter with clear/expire, instantiated only under the macro.

Test Plan:
- AA, 05, 3C on consecutive cycles -> one cycle later WR_EN=1, ADDR=5, WR_DATA=0x3C for exactly 1 cycle; BUSY low after.
- BB, 0A -> RD_EN=1, ADDR=0xA one cycle after the 0A byte. Then BB, 1A -> no RD_EN, FRAME_ERR pulse, state IDLE.
- CC, 12, 34, 0x03, with gaps of 0-5 cycles -> WR_EN writes 0x12@0, then 0x34@1, then ALU_EN with ALU_FUN=3. ALU_CLK_EN is high from the cycle after CC through the ALU_EN cycle.
- DD, F7 -> ALU_EN=1, ALU_FUN=7. Byte 0x55 in IDLE -> FRAME_ERR only.
- RST pulsed after AA, 05 -> no WR_EN. A subsequent AA, 02, 11 writes 0x11@2 normally.
- Timeout build, TIMEOUT_CYC=16: AA, then 15 idle cycles -> FRAME_ERR, IDLE, a following 09 is treated as an illegal opcode. Same with the byte arriving on the 15th idle cycle -> frame continues.

Source files
------------

// File: rtl/sys_ctrl_rx_decoder_pkg.sv
// Shared constants and types for the system-controller UART-RX command decoder.
// The optional inter-byte timeout is enabled by defining SYS_CTRL_RX_TIMEOUT_EN.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ALU_FUN_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    OPA,
    OPB,
    FUN
  } state_t;

  // An address byte is legal only when every bit above the register-file address width is zero.
  function automatic logic addr_legal(input logic [31:0] rx_byte, input int addr_w);
    return (rx_byte >> addr_w) == 32'd0;
  endfunction

endpackage

// File: rtl/sys_ctrl_rx_decoder_if.sv
// Bundle between the UART receiver side and the RegFile/ALU command side of the decoder.
// slave is the decoder's view; master is the view of whatever drives bytes and observes strobes.
interface sys_ctrl_rx_decoder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  logic [DATA_W-1:0]                RX_P_DATA;
  logic                             RX_D_VLD;
  logic                             WR_EN;
  logic                             RD_EN;
  logic [ADDR_W-1:0]                ADDR;
  logic [DATA_W-1:0]                WR_DATA;
  logic                             ALU_EN;
  logic [sys_ctrl_pkg::ALU_FUN_W-1:0] ALU_FUN;
  logic                             ALU_CLK_EN;
  logic                             BUSY;
  logic                             FRAME_ERR;

  modport slave (
    input  RX_P_DATA, RX_D_VLD,
    output WR_EN, RD_EN, ADDR, WR_DATA, ALU_EN, ALU_FUN, ALU_CLK_EN, BUSY, FRAME_ERR
  );

  modport master (
    output RX_P_DATA, RX_D_VLD,
    input  WR_EN, RD_EN, ADDR, WR_DATA, ALU_EN, ALU_FUN, ALU_CLK_EN, BUSY, FRAME_ERR
  );

endinterface

// File: rtl/sys_ctrl_rx_decoder_timeout_cnt.sv
// Inter-byte idle counter: counts idle cycles of a frame in progress and flags the cycle
// in which the idle run reaches its limit. Only instantiated when SYS_CTRL_RX_TIMEOUT_EN is defined.
module sys_ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  // expire fires in the idle cycle whose increment would bring the count to TIMEOUT_CYC-1,
  // so a byte arriving in that same cycle still wins over the timeout.
  assign expire = tick && (count == CNT_W'(TIMEOUT_CYC - 2));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sys_ctrl_rx_decoder.sv
// Second-generation UART-RX command decoder: framed bytes in, registered RegFile/ALU strobes out.
// Define SYS_CTRL_RX_TIMEOUT_EN to abandon frames that stall for TIMEOUT_CYC idle cycles.
module sys_ctrl_rx_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  sys_ctrl_rx_decoder_if.slave   bus
);

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]    addr_hold;
  logic [ADDR_W-1:0]    addr_hold_next;

  logic                 wr_en_next;
  logic                 rd_en_next;
  logic                 alu_en_next;
  logic                 frame_err_next;
  logic                 busy_next;
  logic                 clk_en_next;
  logic [ADDR_W-1:0]    addr_next;
  logic [DATA_W-1:0]    wr_data_next;
  logic [ALU_FUN_W-1:0] fun_next;

  logic                 vld;
  logic [DATA_W-1:0]    rx_byte;
  logic                 byte_ok;
  logic                 timeout;

  assign vld     = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;
  assign byte_ok = addr_legal(32'(rx_byte), ADDR_W);

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  sys_ctrl_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (vld || (state == IDLE)),
    .tick   (!vld && (state != IDLE)),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      addr_hold      <= '0;
      bus.WR_EN      <= 1'b0;
      bus.RD_EN      <= 1'b0;
      bus.ADDR       <= '0;
      bus.WR_DATA    <= '0;
      bus.ALU_EN     <= 1'b0;
      bus.ALU_FUN    <= '0;
      bus.ALU_CLK_EN <= 1'b0;
      bus.BUSY       <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
    end else begin
      state          <= state_next;
      addr_hold      <= addr_hold_next;
      bus.WR_EN      <= wr_en_next;
      bus.RD_EN      <= rd_en_next;
      bus.ADDR       <= addr_next;
      bus.WR_DATA    <= wr_data_next;
      bus.ALU_EN     <= alu_en_next;
      bus.ALU_FUN    <= fun_next;
      bus.ALU_CLK_EN <= clk_en_next;
      bus.BUSY       <= busy_next;
      bus.FRAME_ERR  <= frame_err_next;
    end
  end

  // Outputs are computed for the cycle after the accepting edge, so every strobe is one
  // registered cycle wide and ADDR/WR_DATA/ALU_FUN fall back to zero when nothing fires.
  always_comb begin
    state_next     = state;
    addr_hold_next = addr_hold;
    wr_en_next     = 1'b0;
    rd_en_next     = 1'b0;
    alu_en_next    = 1'b0;
    frame_err_next = 1'b0;
    addr_next      = '0;
    wr_data_next   = '0;
    fun_next       = '0;

    if (timeout) begin
      state_next     = IDLE;
      frame_err_next = 1'b1;
    end else if (vld) begin
      case (state)
        IDLE: begin
          if (rx_byte == DATA_W'(CMD_RF_WR)) begin
            state_next = WR_ADDR;
          end else if (rx_byte == DATA_W'(CMD_RF_RD)) begin
            state_next = RD_ADDR;
          end else if (rx_byte == DATA_W'(CMD_ALU_OP)) begin
            state_next = OPA;
          end else if (rx_byte == DATA_W'(CMD_ALU_NOP)) begin
            state_next = FUN;
          end else begin
            frame_err_next = 1'b1;
          end
        end
        WR_ADDR: begin
          if (byte_ok) begin
            addr_hold_next = rx_byte[ADDR_W-1:0];
            state_next     = WR_DATA;
          end else begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
          end
        end
        WR_DATA: begin
          wr_en_next   = 1'b1;
          addr_next    = addr_hold;
          wr_data_next = rx_byte;
          state_next   = IDLE;
        end
        RD_ADDR: begin
          if (byte_ok) begin
            rd_en_next = 1'b1;
            addr_next  = rx_byte[ADDR_W-1:0];
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
        OPA: begin
          wr_en_next   = 1'b1;
          addr_next    = ADDR_W'(OPA_ADDR);
          wr_data_next = rx_byte;
          state_next   = OPB;
        end
        OPB: begin
          wr_en_next   = 1'b1;
          addr_next    = ADDR_W'(OPB_ADDR);
          wr_data_next = rx_byte;
          state_next   = FUN;
        end
        FUN: begin
          alu_en_next = 1'b1;
          fun_next    = rx_byte[ALU_FUN_W-1:0];
          state_next  = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // BUSY and the ALU clock gate stay up through the completing strobe cycle.
    busy_next   = (state_next != IDLE) || wr_en_next || rd_en_next || alu_en_next;
    clk_en_next = (state_next == OPA) || (state_next == OPB) || (state_next == FUN) || alu_en_next;
  end

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// Self-checking bench for sys_ctrl_rx_decoder: directed byte frames with a scoreboard of expected strobes.
// Timeout scenarios run only when SYS_CTRL_RX_TIMEOUT_EN is defined.
module tb_sys_ctrl_rx_decoder;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       alu;
    logic       ferr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
  } out_t;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;
  out_t exp_q[$];
  string tag_q[$];

  sys_ctrl_rx_decoder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sys_ctrl_rx_decoder #(
    .DATA_W      (8),
    .ADDR_W      (4),
    .OPA_ADDR    (0),
    .OPB_ADDR    (1),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic out_t mk(input logic wr, input logic rd, input logic alu, input logic ferr,
                              input logic [3:0] addr, input logic [7:0] wdata, input logic [3:0] fun);
    out_t o;
    o.wr = wr; o.rd = rd; o.alu = alu; o.ferr = ferr;
    o.addr = addr; o.wdata = wdata; o.fun = fun;
    return o;
  endfunction

  function automatic out_t observed();
    return mk(bus.WR_EN, bus.RD_EN, bus.ALU_EN, bus.FRAME_ERR, bus.ADDR, bus.WR_DATA, bus.ALU_FUN);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at 1ns after a rising edge; returns 1ns after the edge that follows the last gap cycle.
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    bus.RX_D_VLD  = 1'b1;
    bus.RX_P_DATA = b;
    @(posedge CLK);
    #1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_out(input out_t o, input string tag);
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  // Scoreboard monitor: every strobe cycle pops one expectation; quiet cycles must be all zero.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.WR_EN || bus.RD_EN || bus.ALU_EN || bus.FRAME_ERR) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", 32'(observed()), 32'h0);
        end else begin
          check_output(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
        end
      end else begin
        check_output("quiet_outputs", 32'(observed()), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    RST = 1'b1;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    check_output("reset_outputs", 32'(observed()), 32'h0);
    check_output("reset_busy", 32'(bus.BUSY), 32'h0);
    check_output("reset_clk_en", 32'(bus.ALU_CLK_EN), 32'h0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Register write, back-to-back bytes
    expect_out(mk(1, 0, 0, 0, 4'h5, 8'h3C, 4'h0), "rf_write_5");
    apply_stimulus(8'hAA, 0);
    check_output("busy_after_opcode", 32'(bus.BUSY), 32'h1);
    apply_stimulus(8'h05, 0);
    apply_stimulus(8'h3C, 0);
    check_output("wr_en_latency", 32'(bus.WR_EN), 32'h1);
    check_output("busy_in_strobe", 32'(bus.BUSY), 32'h1);
    @(posedge CLK); #1;
    check_output("wr_en_one_cycle", 32'(bus.WR_EN), 32'h0);
    check_output("busy_after_write", 32'(bus.BUSY), 32'h0);

    // Register read: legal then illegal address
    expect_out(mk(0, 1, 0, 0, 4'hA, 8'h00, 4'h0), "rf_read_a");
    apply_stimulus(8'hBB, 0);
    apply_stimulus(8'h0A, 0);
    check_output("rd_en_latency", 32'(bus.RD_EN), 32'h1);
    expect_out(mk(0, 0, 0, 1, 4'h0, 8'h00, 4'h0), "rd_illegal_addr");
    apply_stimulus(8'hBB, 0);
    apply_stimulus(8'h1A, 0);
    check_output("rd_illegal_busy", 32'(bus.BUSY), 32'h0);
    @(posedge CLK); #1;

    // ALU with operands, gapped bytes, clock gate tracking
    expect_out(mk(1, 0, 0, 0, 4'h0, 8'h12, 4'h0), "opa_write");
    expect_out(mk(1, 0, 0, 0, 4'h1, 8'h34, 4'h0), "opb_write");
    expect_out(mk(0, 0, 1, 0, 4'h0, 8'h00, 4'h3), "alu_fun_3");
    check_output("clk_en_before_cc", 32'(bus.ALU_CLK_EN), 32'h0);
    apply_stimulus(8'hCC, 2);
    check_output("clk_en_in_opa", 32'(bus.ALU_CLK_EN), 32'h1);
    apply_stimulus(8'h12, 0);
    check_output("clk_en_in_opb", 32'(bus.ALU_CLK_EN), 32'h1);
    apply_stimulus(8'h34, 5);
    check_output("clk_en_in_fun", 32'(bus.ALU_CLK_EN), 32'h1);
    apply_stimulus(8'h03, 0);
    check_output("clk_en_alu_cycle", 32'(bus.ALU_CLK_EN), 32'h1);
    check_output("alu_en_latency", 32'(bus.ALU_EN), 32'h1);
    @(posedge CLK); #1;
    check_output("clk_en_after_alu", 32'(bus.ALU_CLK_EN), 32'h0);

    // ALU without operands, then an illegal opcode right behind it, then another frame
    expect_out(mk(0, 0, 1, 0, 4'h0, 8'h00, 4'h7), "alu_nop_fun_7");
    expect_out(mk(0, 0, 0, 1, 4'h0, 8'h00, 4'h0), "illegal_opcode_55");
    expect_out(mk(0, 1, 0, 0, 4'hF, 8'h00, 4'h0), "read_after_err");
    apply_stimulus(8'hDD, 0);
    apply_stimulus(8'hF7, 0);
    apply_stimulus(8'h55, 0);
    check_output("busy_on_illegal", 32'(bus.BUSY), 32'h0);
    apply_stimulus(8'hBB, 0);
    apply_stimulus(8'h0F, 0);
    @(posedge CLK); #1;

    // Reset mid-frame discards it; next frame works
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h05, 0);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    check_output("busy_after_reset", 32'(bus.BUSY), 32'h0);
    @(posedge CLK); #1;
    check_output("no_write_after_reset", 32'(bus.WR_EN), 32'h0);
    expect_out(mk(1, 0, 0, 0, 4'h2, 8'h11, 4'h0), "write_after_reset");
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h02, 0);
    apply_stimulus(8'h11, 0);
    @(posedge CLK); #1;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
    // Stall of 15 idle cycles abandons the frame; following 09 is an illegal opcode
    expect_out(mk(0, 0, 0, 1, 4'h0, 8'h00, 4'h0), "timeout_err");
    expect_out(mk(0, 0, 0, 1, 4'h0, 8'h00, 4'h0), "post_timeout_09");
    apply_stimulus(8'hAA, 14);
    @(posedge CLK); #1;
    check_output("timeout_pulse", 32'(bus.FRAME_ERR), 32'h1);
    check_output("timeout_busy", 32'(bus.BUSY), 32'h0);
    apply_stimulus(8'h09, 0);
    @(posedge CLK); #1;

    // Byte landing in the expiry cycle keeps the frame alive
    expect_out(mk(1, 0, 0, 0, 4'h3, 8'h44, 4'h0), "late_byte_write");
    apply_stimulus(8'hAA, 14);
    apply_stimulus(8'h03, 0);
    check_output("late_byte_no_err", 32'(bus.FRAME_ERR), 32'h0);
    check_output("late_byte_busy", 32'(bus.BUSY), 32'h1);
    apply_stimulus(8'h44, 0);
    @(posedge CLK); #1;
`endif

    repeat (3) @(posedge CLK);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
